// File: rtl/video_mnist_pkg.sv
// Shared definitions for the video_mnist register space and its parameter scheduler.
package video_mnist_pkg;

    // Number of host-stageable configuration entries and the width of their index.
    localparam int NUM_ENTRIES = 4;
    localparam int ENTRY_IDX_W = 2;

    // Default word addresses of the registers in video_mnist / video_mnist_color.
    localparam logic [7:0] ADR_BIN_THRESHOLD = 8'h04;
    localparam logic [7:0] ADR_BIN_INVERT    = 8'h05;
    localparam logic [7:0] ADR_COLOR_MODE    = 8'h44;
    localparam logic [7:0] ADR_COLOR_TH      = 8'h45;

    // Scheduler state encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_FE = 3'd1,
        ST_SELECT  = 3'd2,
        ST_WRITE   = 3'd3,
        ST_GAP     = 3'd4
    } sched_state_t;

    // Index of the lowest set bit; 0 when the mask is empty (caller checks the mask).
    function automatic logic [ENTRY_IDX_W-1:0] lowest_index(input logic [NUM_ENTRIES-1:0] mask);
        logic [ENTRY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (mask[i]) idx = ENTRY_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/video_mnist_param_scheduler_if.sv
// Wishbone master bus used by the parameter scheduler to write the register space.
interface video_mnist_param_scheduler_if #(
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic [WB_ADR_WIDTH-1:0] m_wb_adr_o;
    logic [WB_DAT_WIDTH-1:0] m_wb_dat_o;
    logic                    m_wb_we_o;
    logic [WB_SEL_WIDTH-1:0] m_wb_sel_o;
    logic                    m_wb_stb_o;
    logic                    m_wb_ack_i;

    modport master (
        output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
        input  m_wb_ack_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
        output m_wb_ack_i
    );
endinterface

// File: rtl/video_mnist_frame_tracker.sv
// Counts lines of a monitored AXI4-Stream video and pulses frame_end on the last line's tlast.
module video_mnist_frame_tracker
    import video_mnist_pkg::*;
#(
    parameter int IMG_Y_NUM   = 120,
    parameter int IMG_Y_WIDTH = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tuser,
    input  logic tlast,
    input  logic tvalid,
    input  logic tready,
    output logic frame_end
);

    localparam logic [IMG_Y_WIDTH-1:0] LAST_LINE = IMG_Y_WIDTH'(IMG_Y_NUM - 1);

    logic [IMG_Y_WIDTH-1:0] line_q, line_d;
    logic [IMG_Y_WIDTH-1:0] base;
    logic                   beat;

    // tuser restarts the count before tlast is applied; saturated counts still end the frame.
    always_comb begin
        beat      = tvalid & tready;
        base      = (beat && tuser) ? '0 : line_q;
        frame_end = 1'b0;
        line_d    = base;
        if (beat && tlast) begin
            if (base >= LAST_LINE) begin
                frame_end = 1'b1;
                line_d    = '0;
            end else begin
                line_d = base + IMG_Y_WIDTH'(1);
            end
        end
    end

    // Line counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_q <= '0;
        else        line_q <= line_d;
    end

endmodule

// File: rtl/video_mnist_param_scheduler.sv
// Stages host parameter writes and flushes them over Wishbone in the gap after a frame end.
module video_mnist_param_scheduler
    import video_mnist_pkg::*;
#(
    parameter int IMG_Y_NUM     = 120,
    parameter int IMG_Y_WIDTH   = 12,
    parameter int WB_ADR_WIDTH  = 8,
    parameter int WB_DAT_WIDTH  = 32,
    parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter logic [WB_ADR_WIDTH-1:0] ADR_0 = WB_ADR_WIDTH'(ADR_BIN_THRESHOLD),
    parameter logic [WB_ADR_WIDTH-1:0] ADR_1 = WB_ADR_WIDTH'(ADR_BIN_INVERT),
    parameter logic [WB_ADR_WIDTH-1:0] ADR_2 = WB_ADR_WIDTH'(ADR_COLOR_MODE),
    parameter logic [WB_ADR_WIDTH-1:0] ADR_3 = WB_ADR_WIDTH'(ADR_COLOR_TH),
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     mon_tuser,
    input  logic                     mon_tlast,
    input  logic                     mon_tvalid,
    input  logic                     mon_tready,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ENTRY_IDX_W-1:0]   cfg_index,
    input  logic [WB_DAT_WIDTH-1:0]  cfg_data,
    video_mnist_param_scheduler_if.master m_wb,
    output logic                     busy,
    output logic [NUM_ENTRIES-1:0]   pending,
    output logic                     error,
    output logic [15:0]              flush_count
);

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    sched_state_t              state_q, state_d;
    logic [WB_DAT_WIDTH-1:0]   shadow_q [NUM_ENTRIES];
    logic [WB_DAT_WIDTH-1:0]   shadow_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    pending_q, pending_d;
    logic [NUM_ENTRIES-1:0]    done_q, done_d;
    logic [WB_ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_DAT_WIDTH-1:0]   dat_q, dat_d;
    logic                      stb_q, stb_d;
    logic                      we_q, we_d;
    logic [WB_SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                      error_q, error_d;
    logic                      busy_q, busy_d;
    logic [15:0]               fc_q, fc_d;
    logic [TIMEOUT_WIDTH-1:0]  tmo_q, tmo_d;
    logic                      frame_end;
    logic [NUM_ENTRIES-1:0]    avail;
    logic [ENTRY_IDX_W-1:0]    pick;

    function automatic logic [WB_ADR_WIDTH-1:0] entry_addr(input logic [ENTRY_IDX_W-1:0] idx);
        case (idx)
            2'd1:    return ADR_1;
            2'd2:    return ADR_2;
            2'd3:    return ADR_3;
            default: return ADR_0;
        endcase
    endfunction

    video_mnist_frame_tracker #(
        .IMG_Y_NUM   (IMG_Y_NUM),
        .IMG_Y_WIDTH (IMG_Y_WIDTH)
    ) u_frame_tracker (
        .clk       (aclk),
        .rst_n     (aresetn),
        .tuser     (mon_tuser),
        .tlast     (mon_tlast),
        .tvalid    (mon_tvalid),
        .tready    (mon_tready),
        .frame_end (frame_end)
    );

    // Next-state, staging and bus output logic; staging is applied last so a same-cycle beat re-arms pending.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        done_d    = done_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        error_d   = error_q;
        fc_d      = fc_q;
        tmo_d     = tmo_q;
        // Entries already written in this flush wait for the next frame end.
        avail     = pending_q & ~done_q;
        pick      = lowest_index(avail);

        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) state_d = ST_WAIT_FE;
            end
            ST_WAIT_FE: begin
                if (frame_end) begin
                    done_d  = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (avail != '0) begin
                    adr_d           = entry_addr(pick);
                    dat_d           = shadow_q[pick];
                    pending_d[pick] = 1'b0;
                    done_d[pick]    = 1'b1;
                    stb_d           = 1'b1;
                    we_d            = 1'b1;
                    sel_d           = '1;
                    tmo_d           = '0;
                    state_d         = ST_WRITE;
                end else begin
                    fc_d    = fc_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (m_wb.m_wb_ack_i || tmo_q == TMO_LAST) begin
                    // A late ack on the final allowed cycle still counts as success.
                    if (!m_wb.m_wb_ack_i) error_d = 1'b1;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_SELECT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cfg_valid) begin
            shadow_d[cfg_index]  = cfg_data;
            pending_d[cfg_index] = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset clears everything, including an in-flight strobe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_ENTRIES; i++) shadow_q[i] <= '0;
            pending_q <= '0;
            done_q    <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            fc_q      <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            fc_q      <= fc_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cfg_ready       = 1'b1;
    assign m_wb.m_wb_adr_o = adr_q;
    assign m_wb.m_wb_dat_o = dat_q;
    assign m_wb.m_wb_we_o  = we_q;
    assign m_wb.m_wb_sel_o = sel_q;
    assign m_wb.m_wb_stb_o = stb_q;
    assign busy            = busy_q;
    assign pending         = pending_q;
    assign error           = error_q;
    assign flush_count     = fc_q;

endmodule

// File: tb/tb_video_mnist_param_scheduler.sv
// Directed bench for the frame-synchronous parameter scheduler.
module tb_video_mnist_param_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        mon_tuser, mon_tlast, mon_tvalid, mon_tready;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_index;
    logic [31:0] cfg_data;
    logic        busy, error;
    logic [3:0]  pending;
    logic [15:0] flush_count;

    always #5 aclk = ~aclk;

    video_mnist_param_scheduler_if #(.WB_ADR_WIDTH(8), .WB_DAT_WIDTH(32), .WB_SEL_WIDTH(4)) wb ();

    video_mnist_param_scheduler #(.TIMEOUT(10)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .mon_tuser   (mon_tuser),
        .mon_tlast   (mon_tlast),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_index   (cfg_index),
        .cfg_data    (cfg_data),
        .m_wb        (wb),
        .busy        (busy),
        .pending     (pending),
        .error       (error),
        .flush_count (flush_count)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Wishbone slave model and write log.
    int          ack_lat = 1;
    bit          ack_en  = 1'b1;
    int          scnt    = 0;
    logic        prev_stb = 1'b0;
    logic [7:0]  wr_adr[$];
    logic [31:0] wr_dat[$];
    int          rise_cyc[$];
    int          stb_len[$];
    int          fe_cyc = 0;
    int          exp_fc = 0;

    initial begin
        wb.m_wb_ack_i = 1'b0;
        forever begin
            @(negedge aclk);
            if (wb.m_wb_stb_o === 1'b1) begin
                if (!prev_stb) rise_cyc.push_back(cyc);
                scnt++;
                if (ack_en && scnt >= ack_lat) begin
                    wb.m_wb_ack_i = 1'b1;
                    wr_adr.push_back(wb.m_wb_adr_o);
                    wr_dat.push_back(wb.m_wb_dat_o);
                end else begin
                    wb.m_wb_ack_i = 1'b0;
                end
            end else begin
                if (prev_stb) stb_len.push_back(scnt);
                scnt = 0;
                wb.m_wb_ack_i = 1'b0;
            end
            prev_stb = (wb.m_wb_stb_o === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        rise_cyc.delete();
        stb_len.delete();
    endtask

    task automatic stage(input logic [1:0] idx, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_index = idx;
        cfg_data  = data;
        @(negedge aclk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input int width);
        for (int ln = 0; ln < 120; ln++) begin
            for (int px = 0; px < width; px++) begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b1;
                mon_tuser  = (ln == 0 && px == 0);
                mon_tlast  = (px == width - 1);
                if (ln == 119 && px == width - 1) fe_cyc = cyc;
                @(negedge aclk);
            end
        end
        mon_tvalid = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge aclk);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 2000) chk({name, " idle wait expired"}, 64'd1, 64'd0);
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        while (wb.m_wb_stb_o !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) chk({name, " stb wait expired"}, 64'd1, 64'd0);
    endtask

    function automatic logic [63:0] q_adr(input int i);
        return (i < wr_adr.size()) ? 64'(wr_adr[i]) : 64'hx;
    endfunction

    function automatic logic [63:0] q_dat(input int i);
        return (i < wr_dat.size()) ? 64'(wr_dat[i]) : 64'hx;
    endfunction

    typedef struct {
        int               nst;
        logic [3:0][1:0]  sidx;
        logic [3:0][31:0] sdat;
        int               nw;
        logic [3:0][7:0]  wadr;
        logic [3:0][31:0] wdat;
        int               lat;
        int               width;
    } vec_t;

    vec_t tv[4];

    initial begin
        int n;
        // Vector table: staged entries and the writes each flush must produce, in order.
        tv[0].nst = 1; tv[0].sidx[0] = 2'd0; tv[0].sdat[0] = 32'h7F;
        tv[0].nw  = 1; tv[0].wadr[0] = 8'h04; tv[0].wdat[0] = 32'h7F;
        tv[0].lat = 1; tv[0].width = 160;

        tv[1].nst = 3;
        tv[1].sidx[0] = 2'd3; tv[1].sdat[0] = 32'h33;
        tv[1].sidx[1] = 2'd1; tv[1].sdat[1] = 32'h11;
        tv[1].sidx[2] = 2'd0; tv[1].sdat[2] = 32'h10;
        tv[1].nw  = 3;
        tv[1].wadr[0] = 8'h04; tv[1].wdat[0] = 32'h10;
        tv[1].wadr[1] = 8'h05; tv[1].wdat[1] = 32'h11;
        tv[1].wadr[2] = 8'h45; tv[1].wdat[2] = 32'h33;
        tv[1].lat = 2; tv[1].width = 4;

        tv[2].nst = 2;
        tv[2].sidx[0] = 2'd2; tv[2].sdat[0] = 32'h1;
        tv[2].sidx[1] = 2'd2; tv[2].sdat[1] = 32'h2;
        tv[2].nw  = 1; tv[2].wadr[0] = 8'h44; tv[2].wdat[0] = 32'h2;
        tv[2].lat = 1; tv[2].width = 4;

        tv[3].nst = 4;
        tv[3].sidx[0] = 2'd2; tv[3].sdat[0] = 32'hCAFE0002;
        tv[3].sidx[1] = 2'd0; tv[3].sdat[1] = 32'h000000FF;
        tv[3].sidx[2] = 2'd3; tv[3].sdat[2] = 32'hDEADBEEF;
        tv[3].sidx[3] = 2'd1; tv[3].sdat[3] = 32'h00000001;
        tv[3].nw  = 4;
        tv[3].wadr[0] = 8'h04; tv[3].wdat[0] = 32'h000000FF;
        tv[3].wadr[1] = 8'h05; tv[3].wdat[1] = 32'h00000001;
        tv[3].wadr[2] = 8'h44; tv[3].wdat[2] = 32'hCAFE0002;
        tv[3].wadr[3] = 8'h45; tv[3].wdat[3] = 32'hDEADBEEF;
        tv[3].lat = 3; tv[3].width = 4;

        aresetn    = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        cfg_valid  = 1'b0;
        cfg_index  = 2'd0;
        cfg_data   = 32'd0;
        repeat (3) @(negedge aclk);

        chk("reset stb", 64'(wb.m_wb_stb_o), 64'd0);
        chk("reset we", 64'(wb.m_wb_we_o), 64'd0);
        chk("reset adr", 64'(wb.m_wb_adr_o), 64'd0);
        chk("reset dat", 64'(wb.m_wb_dat_o), 64'd0);
        chk("reset sel", 64'(wb.m_wb_sel_o), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        chk("reset flush_count", 64'(flush_count), 64'd0);
        chk("cfg_ready", 64'(cfg_ready), 64'd1);

        aresetn = 1'b1;
        @(negedge aclk);

        for (int v = 0; v < 4; v++) begin
            clear_log();
            ack_lat = tv[v].lat;
            for (int s = 0; s < tv[v].nst; s++) stage(tv[v].sidx[s], tv[v].sdat[s]);
            chk($sformatf("v%0d no write before frame end", v), 64'(wr_adr.size()), 64'd0);
            send_frame(tv[v].width);
            wait_idle($sformatf("v%0d", v));
            exp_fc++;
            chk($sformatf("v%0d write count", v), 64'(wr_adr.size()), 64'(tv[v].nw));
            for (int w = 0; w < tv[v].nw; w++) begin
                chk($sformatf("v%0d adr%0d", v, w), q_adr(w), 64'(tv[v].wadr[w]));
                chk($sformatf("v%0d dat%0d", v, w), q_dat(w), 64'(tv[v].wdat[w]));
                if (w < rise_cyc.size()) begin
                    if (w == 0)
                        chk($sformatf("v%0d first stb latency", v), 64'(rise_cyc[0] - fe_cyc), 64'd2);
                    else
                        chk($sformatf("v%0d stb spacing%0d", v, w),
                            64'(rise_cyc[w] - rise_cyc[w-1]), 64'(tv[v].lat + 2));
                end else begin
                    chk($sformatf("v%0d stb rise%0d missing", v, w), 64'(rise_cyc.size()), 64'(w + 1));
                end
            end
            chk($sformatf("v%0d pending", v), 64'(pending), 64'd0);
            chk($sformatf("v%0d flush_count", v), 64'(flush_count), 64'(exp_fc));
            chk($sformatf("v%0d error", v), 64'(error), 64'd0);
        end

        // Entries staged while entry 0 is being written.
        clear_log();
        ack_lat = 3;
        stage(2'd0, 32'h01);
        send_frame(4);
        wait_stb("midflush");
        stage(2'd0, 32'h55);
        stage(2'd2, 32'h66);
        wait_idle("midflush");
        exp_fc++;
        chk("midflush write count", 64'(wr_adr.size()), 64'd2);
        chk("midflush adr0", q_adr(0), 64'h04);
        chk("midflush dat0", q_dat(0), 64'h01);
        chk("midflush adr1", q_adr(1), 64'h44);
        chk("midflush dat1", q_dat(1), 64'h66);
        chk("midflush pending", 64'(pending), 64'b0001);
        chk("midflush flush_count", 64'(flush_count), 64'(exp_fc));
        clear_log();
        send_frame(4);
        wait_idle("midflush next");
        exp_fc++;
        chk("midflush next count", 64'(wr_adr.size()), 64'd1);
        chk("midflush next adr", q_adr(0), 64'h04);
        chk("midflush next dat", q_dat(0), 64'h55);
        chk("midflush next pending", 64'(pending), 64'd0);

        // Timeout on entry 0, entry 1 still flushed.
        clear_log();
        ack_en  = 1'b0;
        ack_lat = 1;
        stage(2'd0, 32'hA0);
        stage(2'd1, 32'hA1);
        send_frame(4);
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) chk("timeout error wait expired", 64'd1, 64'd0);
        ack_en = 1'b1;
        wait_idle("timeout");
        exp_fc++;
        chk("timeout stb length", (stb_len.size() > 0) ? 64'(stb_len[0]) : 64'hx, 64'd10);
        chk("timeout error", 64'(error), 64'd1);
        chk("timeout write count", 64'(wr_adr.size()), 64'd1);
        chk("timeout next adr", q_adr(0), 64'h05);
        chk("timeout next dat", q_dat(0), 64'hA1);
        chk("timeout pending", 64'(pending), 64'd0);
        chk("timeout flush_count", 64'(flush_count), 64'(exp_fc));

        // Asynchronous reset in the middle of a write.
        clear_log();
        ack_en = 1'b0;
        stage(2'd3, 32'h12345678);
        send_frame(4);
        wait_stb("reset midwrite");
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("midreset stb", 64'(wb.m_wb_stb_o), 64'd0);
        chk("midreset we", 64'(wb.m_wb_we_o), 64'd0);
        chk("midreset adr", 64'(wb.m_wb_adr_o), 64'd0);
        chk("midreset dat", 64'(wb.m_wb_dat_o), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset pending", 64'(pending), 64'd0);
        chk("midreset error", 64'(error), 64'd0);
        chk("midreset flush_count", 64'(flush_count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        ack_en  = 1'b1;
        @(negedge aclk);
        clear_log();
        send_frame(4);
        repeat (20) @(negedge aclk);
        chk("postreset writes", 64'(wr_adr.size()), 64'd0);
        chk("postreset busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
